blockmix_ctrl: RTL

//  Sequences one salsa20_8 core through the scrypt BlockMix (r=1) on a 1024-bit block B=(B0,B1):
//  X=B1; X=Salsa(X^B0) -> Y0; X=Salsa(X^B1) -> Y1; output B'=(Y0,Y1).

---
 rtl/blockmix_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/blockmix_ctrl.sv
// blockmix_ctrl: sequences a shared salsa20_8 core through one scrypt
// BlockMix (r=1) pass pair on a 1024-bit block B = (B0, B1).
//   X = B1; Y0 = Salsa(X ^ B0); Y1 = Salsa(Y0 ^ B1); B' = (Y0, Y1)
// The block owns the core's enable/data inputs and aborts with a one-cycle
// err pulse if the core does not report hash_done within MAX_WAIT cycles.
module blockmix_ctrl #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 7
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          start,
  input  logic [1023:0] b_in,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1023:0] b_out,
  output logic          salsa_enable,
  output logic [511:0]  salsa_data,
  input  logic [511:0]  salsa_out,
  input  logic          salsa_hash_done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ISSUE0 = 3'd1;
  localparam logic [2:0] WAIT0  = 3'd2;
  localparam logic [2:0] ISSUE1 = 3'd3;
  localparam logic [2:0] WAIT1  = 3'd4;
  localparam logic [2:0] FIN    = 3'd5;

  // The last WAIT cycle is the one whose increment would bring the counter
  // to MAX_WAIT; a hash_done arriving in that same cycle still completes the
  // pass. Counted from the enable cycle, the abort lands MAX_WAIT cycles later.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [511:0]     b1_reg;
  logic [511:0]     y0_reg;
  logic             in_wait;
  logic             timeout;

  // Status and core handshake outputs are decoded from the state alone, so
  // enable, done and err can never overlap and all read 0 right after reset.
  always_comb begin
    in_wait      = (state == WAIT0) || (state == WAIT1);
    timeout      = in_wait && !salsa_hash_done && (wait_cnt == LAST_CNT);
    busy         = (state != IDLE);
    salsa_enable = (state == ISSUE0) || (state == ISSUE1);
    done         = (state == FIN);
    err          = timeout;
  end

  // Sequencer: captures the block, feeds each salsa pass, collects results.
  // b_out is written on the edge that leaves WAIT1 so it is already valid
  // during the FIN cycle that pulses done.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      b1_reg     <= '0;
      y0_reg     <= '0;
      salsa_data <= '0;
      b_out      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            b1_reg     <= b_in[1023:512];
            salsa_data <= b_in[1023:512] ^ b_in[511:0];
            state      <= ISSUE0;
          end
        end
        ISSUE0: begin
          wait_cnt <= '0;
          state    <= WAIT0;
        end
        WAIT0: begin
          if (salsa_hash_done) begin
            y0_reg     <= salsa_out;
            salsa_data <= salsa_out ^ b1_reg;
            state      <= ISSUE1;
          end else if (timeout) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ISSUE1: begin
          wait_cnt <= '0;
          state    <= WAIT1;
        end
        WAIT1: begin
          if (salsa_hash_done) begin
            b_out <= {salsa_out, y0_reg};
            state <= FIN;
          end else if (timeout) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
